rename_stage: RTL and testbench

- Register-rename stage directly upstream of dispatch; converts decoded architectural operands into physical tags.
- Holds the speculative rename map table (arch→phys), the busy/ready table, and the physical-register free list.
- Produces one renamed instruction per cycle to dispatch over a valid/ready handshake.
- Recycles physical tags on commit and clears busy bits on writeback.

---
 rtl/rename_stage_pkg.sv | 18 +
 rtl/rename_stage_if.sv | 39 +++
 rtl/rename_free_list.sv | 43 ++++
 rtl/rename_stage.sv | 84 ++++++++
 tb/tb_rename_stage.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/rename_stage_pkg.sv
// rezzmaster: rename-stage constants, tag type and the renamed-instruction record consumed by dispatch
package rezzmaster;
  localparam int ARCH_REGS = 32;
  localparam int PTAG_W = 7;
  typedef logic [PTAG_W-1:0] ptag_t;
  typedef logic [$clog2(ARCH_REGS)-1:0] areg_t;
  typedef struct packed {
    ptag_t       rd_ptag;
    ptag_t       old_rd_ptag;
    ptag_t       rs1_ptag;
    logic        rs1_rdy;
    ptag_t       rs2_ptag;
    logic        rs2_rdy;
    logic        has_rd;
    logic [31:0] imm;
    logic [2:0]  fu;
  } renamed_instr_t;
endpackage

// File: rtl/rename_stage_if.sv
// rename_stage_if: decode-side, dispatch-side, writeback and commit signals of the rename stage
interface rename_stage_if;
  import rezzmaster::*;
  logic        in_valid;
  logic        in_ready;
  areg_t       in_rs1;
  areg_t       in_rs2;
  areg_t       in_rd;
  logic        in_has_rd;
  logic [31:0] in_imm;
  logic [2:0]  in_fu;
  logic        out_valid;
  logic        out_ready;
  ptag_t       out_rd_ptag;
  ptag_t       out_old_rd_ptag;
  ptag_t       out_rs1_ptag;
  ptag_t       out_rs2_ptag;
  logic        out_rs1_rdy;
  logic        out_rs2_rdy;
  logic        out_has_rd;
  logic [31:0] out_imm;
  logic [2:0]  out_fu;
  logic        wb_valid;
  ptag_t       wb_ptag;
  logic        commit_valid;
  ptag_t       commit_free_ptag;
  modport slave (
    input  in_valid, in_rs1, in_rs2, in_rd, in_has_rd, in_imm, in_fu,
    input  out_ready, wb_valid, wb_ptag, commit_valid, commit_free_ptag,
    output in_ready, out_valid, out_rd_ptag, out_old_rd_ptag, out_rs1_ptag, out_rs2_ptag,
    output out_rs1_rdy, out_rs2_rdy, out_has_rd, out_imm, out_fu
  );
  modport master (
    output in_valid, in_rs1, in_rs2, in_rd, in_has_rd, in_imm, in_fu,
    output out_ready, wb_valid, wb_ptag, commit_valid, commit_free_ptag,
    input  in_ready, out_valid, out_rd_ptag, out_old_rd_ptag, out_rs1_ptag, out_rs2_ptag,
    input  out_rs1_rdy, out_rs2_rdy, out_has_rd, out_imm, out_fu
  );
endinterface

// File: rtl/rename_free_list.sv
// rename_free_list: circular FIFO of free physical tags, preloaded at reset with FIRST..DEPTH-1
module rename_free_list import rezzmaster::*; #(
  parameter int DEPTH = 64,
  parameter int FIRST = ARCH_REGS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push_i,
  input  ptag_t                        push_ptag_i,
  input  logic                         pop_i,
  output ptag_t                        head_ptag_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         empty_o
);
  localparam int CAP = DEPTH - FIRST;
  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  ptag_t         mem_q [DEPTH];
  logic [IW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  always_comb begin
    head_d  = pop_i ? (head_q == IW'(DEPTH - 1) ? '0 : head_q + IW'(1)) : head_q;
    tail_d  = push_i ? (tail_q == IW'(DEPTH - 1) ? '0 : tail_q + IW'(1)) : tail_q;
    count_d = count_q + CW'(push_i) - CW'(pop_i);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= i < CAP ? ptag_t'(FIRST + i) : '0;
      head_q  <= '0;
      tail_q  <= IW'(CAP);
      count_q <= CW'(CAP);
    end else begin
      if (push_i) mem_q[tail_q] <= push_ptag_i;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  assign head_ptag_o = mem_q[head_q];
  assign count_o     = count_q;
  assign empty_o     = count_q == '0;
  // Every tag is either mapped, in flight to commit, or here; a push into a full list means a tag was freed twice.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && count_q == CW'(CAP)));
endmodule

// File: rtl/rename_stage.sv
// rename_stage: speculative map table, busy table and free list producing one renamed instruction per cycle.
// Define RENAME_FREELIST_BYPASS_EN to hand a committing tag straight to an allocation when the free list is empty.
module rename_stage import rezzmaster::*; #(
  parameter int PHYS_REGS = 64
) (
  input logic           clk,
  input logic           rst_n,
  rename_stage_if.slave rif
);
  localparam int CW = $clog2(PHYS_REGS + 1);
  ptag_t                map_q [ARCH_REGS];
  logic [2**PTAG_W-1:0] busy_q, busy_d;
  renamed_instr_t       out_q, out_d, ren;
  logic                 out_valid_q, out_valid_d;
  logic                 need_alloc, free_empty, bypass, in_ready, accept, alloc, push, pop;
  ptag_t                new_tag, fl_head, rs1_tag, rs2_tag;
  logic [CW-1:0]        fl_count;
  rename_free_list #(.DEPTH(PHYS_REGS), .FIRST(ARCH_REGS)) u_free_list (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .push_ptag_i (rif.commit_free_ptag),
    .pop_i       (pop),
    .head_ptag_o (fl_head),
    .count_o     (fl_count),
    .empty_o     (free_empty)
  );
  always_comb begin
    need_alloc = rif.in_has_rd && rif.in_rd != '0;
`ifdef RENAME_FREELIST_BYPASS_EN
    bypass = need_alloc && free_empty && rif.commit_valid;
`else
    bypass = 1'b0;
`endif
    in_ready = (!out_valid_q || rif.out_ready) && !(need_alloc && free_empty && !bypass);
    accept   = rif.in_valid && in_ready;
    alloc    = accept && need_alloc;
    pop      = alloc && !bypass;
    push     = rif.commit_valid && !(alloc && bypass);
    new_tag  = bypass ? rif.commit_free_ptag : fl_head;
    // Sources see the map as it was before this instruction's own destination update.
    rs1_tag  = rif.in_rs1 == '0 ? '0 : map_q[rif.in_rs1];
    rs2_tag  = rif.in_rs2 == '0 ? '0 : map_q[rif.in_rs2];
    ren.rd_ptag     = alloc ? new_tag : '0;
    ren.old_rd_ptag = alloc ? map_q[rif.in_rd] : '0;
    ren.rs1_ptag    = rs1_tag;
    ren.rs1_rdy     = rif.in_rs1 == '0 || !busy_q[rs1_tag] || (rif.wb_valid && rif.wb_ptag == rs1_tag);
    ren.rs2_ptag    = rs2_tag;
    ren.rs2_rdy     = rif.in_rs2 == '0 || !busy_q[rs2_tag] || (rif.wb_valid && rif.wb_ptag == rs2_tag);
    ren.has_rd      = rif.in_has_rd;
    ren.imm         = rif.in_imm;
    ren.fu          = rif.in_fu;
    out_d       = accept ? ren : out_q;
    out_valid_d = accept || (out_valid_q && !rif.out_ready);
    // Allocation is applied after writeback so a recycled tag comes out busy.
    busy_d = busy_q;
    if (rif.wb_valid && rif.wb_ptag != '0) busy_d[rif.wb_ptag] = 1'b0;
    if (alloc) busy_d[new_tag] = 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < ARCH_REGS; i++) map_q[i] <= ptag_t'(i);
      busy_q      <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (alloc) map_q[rif.in_rd] <= new_tag;
      busy_q      <= busy_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  assign rif.in_ready        = in_ready;
  assign rif.out_valid       = out_valid_q;
  assign rif.out_rd_ptag     = out_q.rd_ptag;
  assign rif.out_old_rd_ptag = out_q.old_rd_ptag;
  assign rif.out_rs1_ptag    = out_q.rs1_ptag;
  assign rif.out_rs1_rdy     = out_q.rs1_rdy;
  assign rif.out_rs2_ptag    = out_q.rs2_ptag;
  assign rif.out_rs2_rdy     = out_q.rs2_rdy;
  assign rif.out_has_rd      = out_q.has_rd;
  assign rif.out_imm         = out_q.imm;
  assign rif.out_fu          = out_q.fu;
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) fl_count <= CW'(PHYS_REGS - ARCH_REGS));
endmodule

// File: tb/tb_rename_stage.sv
// tb_rename_stage: directed and randomized stimulus scored against a queue/array model of the rename rules
module tb_rename_stage;
  import rezzmaster::*;
  localparam int PHYS = 64;
`ifdef RENAME_FREELIST_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  int amap [ARCH_REGS];
  bit busy [128];
  int fl [$];
  int retire [$];
  renamed_instr_t q [$];

  rename_stage_if rif ();
  rename_stage #(.PHYS_REGS(PHYS)) dut (.clk(clk), .rst_n(rst_n), .rif(rif));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ARCH_REGS; i++) amap[i] = i;
    for (int i = 0; i < 128; i++) busy[i] = 1'b0;
    fl.delete();
    retire.delete();
    q.delete();
    for (int i = ARCH_REGS; i < PHYS; i++) fl.push_back(i);
  endtask

  function automatic logic [127:0] dut_out();
    return 128'({rif.out_rd_ptag, rif.out_old_rd_ptag, rif.out_rs1_ptag, rif.out_rs1_rdy,
                 rif.out_rs2_ptag, rif.out_rs2_rdy, rif.out_has_rd, rif.out_imm, rif.out_fu});
  endfunction

  // Monitor: mid-cycle, compare the presented instruction to the oldest expected one and retire it on handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("out_valid", 128'(rif.out_valid), 128'(q.size() != 0));
      if (rif.out_valid && q.size() != 0) begin
        chk("out_instr", dut_out(), 128'(q[0]));
        if (rif.out_ready) void'(q.pop_front());
      end
    end
  end

  // One clock of stimulus; ci indexes the retire list for a commit (-1 = none).
  task automatic step(input bit v, input int rs1, input int rs2, input int rd, input bit hrd,
                      input bit ordy, input bit wv, input int wt, input int ci, output bit rdy);
    bit na, cv, byp, exp_rdy, acc, alloc;
    int ct, tag;
    renamed_instr_t e;
    cv = ci >= 0 && ci < retire.size();
    ct = cv ? retire[ci] : 0;
    rif.in_valid = v;
    rif.in_rs1 = 5'(rs1);
    rif.in_rs2 = 5'(rs2);
    rif.in_rd = 5'(rd);
    rif.in_has_rd = hrd;
    rif.in_imm = $urandom();
    rif.in_fu = 3'(1 << $urandom_range(0, 2));
    rif.out_ready = ordy;
    rif.wb_valid = wv;
    rif.wb_ptag = ptag_t'(wt);
    rif.commit_valid = cv;
    rif.commit_free_ptag = ptag_t'(ct);
    #1;
    na = hrd && rd != 0;
    byp = BYP && na && fl.size() == 0 && cv;
    exp_rdy = (q.size() == 0 || ordy) && !(na && fl.size() == 0 && !byp);
    chk("in_ready", 128'(rif.in_ready), 128'(exp_rdy));
    rdy = rif.in_ready;
    acc = v && exp_rdy;
    alloc = acc && na;
    tag = !alloc ? 0 : byp ? ct : fl[0];
    e.rd_ptag = ptag_t'(tag);
    e.old_rd_ptag = ptag_t'(alloc ? amap[rd] : 0);
    e.rs1_ptag = ptag_t'(rs1 == 0 ? 0 : amap[rs1]);
    e.rs1_rdy = rs1 == 0 || !busy[amap[rs1]] || (wv && wt == amap[rs1]);
    e.rs2_ptag = ptag_t'(rs2 == 0 ? 0 : amap[rs2]);
    e.rs2_rdy = rs2 == 0 || !busy[amap[rs2]] || (wv && wt == amap[rs2]);
    e.has_rd = hrd;
    e.imm = rif.in_imm;
    e.fu = rif.in_fu;
    @(posedge clk);
    if (acc) q.push_back(e);
    if (alloc) begin
      if (!byp) void'(fl.pop_front());
      retire.push_back(amap[rd]);
      amap[rd] = tag;
    end
    if (cv) begin
      retire.delete(ci);
      if (!(alloc && byp)) fl.push_back(ct);
    end
    if (wv && wt != 0) busy[wt] = 1'b0;
    if (alloc) busy[tag] = 1'b1;
    #1;
  endtask

  initial begin
    bit r;
    int idx, ci;
    model_reset();
    rif.in_valid = 1'b0;
    rif.in_rs1 = '0;
    rif.in_rs2 = '0;
    rif.in_rd = '0;
    rif.in_has_rd = 1'b0;
    rif.in_imm = '0;
    rif.in_fu = '0;
    rif.out_ready = 1'b0;
    rif.wb_valid = 1'b0;
    rif.wb_ptag = '0;
    rif.commit_valid = 1'b0;
    rif.commit_free_ptag = '0;
    #12;
    chk("rst_out_valid", 128'(rif.out_valid), 128'(0));
    chk("rst_out_fields", dut_out(), 128'(0));
    chk("rst_in_ready", 128'(rif.in_ready), 128'(1));
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 1, 2, 5, 1, 1, 0, 0, -1, r);
    chk("A_rd_ptag", 128'(rif.out_rd_ptag), 128'(32));
    chk("A_old_rd_ptag", 128'(rif.out_old_rd_ptag), 128'(5));
    chk("A_rs_ptags", 128'({rif.out_rs1_ptag, rif.out_rs2_ptag}), 128'({7'd1, 7'd2}));
    chk("A_rs_rdy", 128'({rif.out_rs1_rdy, rif.out_rs2_rdy}), 128'(2'b11));
    step(1, 5, 0, 6, 1, 1, 0, 0, -1, r);
    chk("B_rs1_ptag", 128'(rif.out_rs1_ptag), 128'(32));
    chk("B_rs1_busy", 128'(rif.out_rs1_rdy), 128'(0));
    step(1, 5, 0, 7, 1, 1, 1, 32, -1, r);
    chk("C_wb_bypass_rdy", 128'(rif.out_rs1_rdy), 128'(1));
    step(1, 3, 3, 3, 1, 1, 0, 0, -1, r);
    chk("D_rs1_old_map", 128'(rif.out_rs1_ptag), 128'(3));
    chk("D_rd_ptag", 128'(rif.out_rd_ptag), 128'(35));
    step(1, 1, 1, 0, 1, 1, 0, 0, -1, r);
    chk("E_rd0_ptag", 128'({rif.out_rd_ptag, rif.out_old_rd_ptag}), 128'(0));
    step(1, 1, 2, 10, 1, 1, 0, 0, -1, r);
    chk("F_rd_ptag", 128'(rif.out_rd_ptag), 128'(36));
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 2, 11, 1, 0, 0, 0, -1, r);
      chk("hold_in_ready", 128'(r), 128'(0));
      chk("hold_rd_ptag", 128'(rif.out_rd_ptag), 128'(36));
    end
    step(1, 1, 2, 11, 1, 1, 0, 0, -1, r);
    chk("release_rd_ptag", 128'(rif.out_rd_ptag), 128'(37));
    for (int i = 0; i < 64 && fl.size() > 0; i++)
      step(1, $urandom_range(0, 31), $urandom_range(0, 31), 8 + fl.size() % 24, 1, 1, 0, 0, -1, r);
    idx = -1;
    for (int i = 0; i < retire.size(); i++) if (retire[i] == 7) idx = i;
    step(1, 1, 2, 9, 1, 1, 0, 0, idx, r);
`ifdef RENAME_FREELIST_BYPASS_EN
    chk("bypass_in_ready", 128'(r), 128'(1));
    chk("bypass_rd_ptag", 128'(rif.out_rd_ptag), 128'(7));
`else
    chk("empty_stall_ready", 128'(r), 128'(0));
    step(1, 1, 2, 9, 1, 1, 0, 0, -1, r);
    chk("recycled_rd_ptag", 128'(rif.out_rd_ptag), 128'(7));
`endif
    for (int i = 0; i < 600; i++) begin
      ci = (retire.size() > 0 && $urandom_range(0, 9) < 4) ? int'($urandom_range(0, retire.size() - 1)) : -1;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
           $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 63), ci, r);
    end
    step(1, 1, 2, 0, 0, 1, 0, 0, -1, r);
    chk("pre_rst_valid", 128'(rif.out_valid), 128'(1));
    #2;
    rst_n = 1'b0;
    rif.in_valid = 1'b0;
    rif.wb_valid = 1'b0;
    rif.commit_valid = 1'b0;
    #1;
    chk("midrst_out_valid", 128'(rif.out_valid), 128'(0));
    chk("midrst_out_fields", dut_out(), 128'(0));
    model_reset();
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1, 5, 31, 5, 1, 1, 0, 0, -1, r);
    chk("post_rst_rs1_map", 128'({rif.out_rs1_ptag, rif.out_rs2_ptag}), 128'({7'd5, 7'd31}));
    chk("post_rst_rd_ptag", 128'({rif.out_rd_ptag, rif.out_old_rd_ptag}), 128'({7'd32, 7'd5}));
    chk("post_rst_rdy", 128'({rif.out_rs1_rdy, rif.out_rs2_rdy}), 128'(2'b11));
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 0, 0, -1, r);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
